axi_timer_mc: RTL and testbench

//  Parametrised multi-channel AXI-lite timer; successor to the single-channel stub.
//  NUM_CH independent CNT_W-bit up-counters share one prescaler and one AXI-lite slave port.
//  Per-channel periodic/one-shot mode, per-channel IRQ enable, W1C pending bits, one combined irq_out.

---
 rtl/axi_timer_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_timer_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_timer_mc.sv
// axi_timer_mc: NUM_CH up-counters, shared prescaler, AXI-lite CSRs.
// Define TIMER_PWM_EN for per-channel CMP registers and pwm_out.
module axi_timer_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [11:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
`ifdef TIMER_PWM_EN
  output logic [NUM_CH-1:0] pwm_out,
`endif
  output logic        irq_out
);

  localparam logic [4:0] NCH    = 5'(NUM_CH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef TIMER_PWM_EN
  localparam bit HAS_CMP = 1'b1;
`else
  localparam bit HAS_CMP = 1'b0;
`endif

  function automatic logic [31:0] smask(logic [3:0] s);
    for (int b = 0; b < 4; b++) smask[8*b +: 8] = {8{s[b]}};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] w,
                                        logic [3:0]  s);
    merge = (o & ~smask(s)) | (w & smask(s));
  endfunction

  function automatic logic ch_sel(logic [11:0] a, int n);
    ch_sel = (a[11:8] == 4'h1) && (a[7:4] == 4'(n));
  endfunction

  // COUNT is read-only, so it only counts as mapped for reads
  function automatic logic mapped(logic [11:0] a, logic wr);
    logic chreg;
    chreg = (a[11:8] == 4'h1) && ({1'b0, a[7:4]} < NCH);
    if (a == 12'h000 || a == 12'h004) return 1'b1;
    case (a[3:0])
      4'h0, 4'h4: return chreg;
      4'h8:       return chreg & ~wr;
      4'hC:       return chreg & HAS_CMP;
      default:    return 1'b0;
    endcase
  endfunction

  logic [PRESC_W-1:0] presc_q, presc_d, psc_q, psc_d;
  logic [2:0]         ctrl_q   [NUM_CH];
  logic [2:0]         ctrl_d   [NUM_CH];
  logic [CNT_W-1:0]   reload_q [NUM_CH];
  logic [CNT_W-1:0]   reload_d [NUM_CH];
  logic [CNT_W-1:0]   count_q  [NUM_CH];
  logic [CNT_W-1:0]   count_d  [NUM_CH];
`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0]   cmp_q    [NUM_CH];
  logic [CNT_W-1:0]   cmp_d    [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q;
`endif
  logic [NUM_CH-1:0]  pend_q, pend_d, hit, clr, ien;
  logic               irq_q, any_en, tick;
  logic               bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [31:0]        rdata_q, rd_mux, wtmp;
  logic               wr_fire, rd_fire;

  assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_fire       = s_axi_arvalid & ~rvalid_q;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = rd_fire;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign irq_out       = irq_q;
`ifdef TIMER_PWM_EN
  assign pwm_out       = pwm_q;
`endif

  // shared prescaler: runs while any channel is enabled
  always_comb begin
    any_en = 1'b0;
    ien    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      any_en = any_en | ctrl_q[n][0];
      ien[n] = ctrl_q[n][2];
    end
    tick = any_en && (psc_q >= presc_q);
    if (!any_en || tick) psc_d = '0;
    else                 psc_d = psc_q + 1'b1;
  end

  // channel counters and CSR writes; a CSR write beats the one-shot clear
  always_comb begin
    wtmp    = '0;
    presc_d = presc_q;
    hit     = '0;
    clr     = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ctrl_d[n]   = ctrl_q[n];
      reload_d[n] = reload_q[n];
      count_d[n]  = count_q[n];
`ifdef TIMER_PWM_EN
      cmp_d[n]    = cmp_q[n];
`endif
      if (!ctrl_q[n][0]) begin
        count_d[n] = '0;
      end else if (tick) begin
        if (count_q[n] >= reload_q[n]) begin
          count_d[n] = '0;
          hit[n]     = 1'b1;
          if (ctrl_q[n][1]) ctrl_d[n][0] = 1'b0;
        end else begin
          count_d[n] = count_q[n] + 1'b1;
        end
      end
      if (wr_fire && ch_sel(s_axi_awaddr, n)) begin
        case (s_axi_awaddr[3:0])
          4'h0: begin
            wtmp = merge(32'(ctrl_q[n]), s_axi_wdata, s_axi_wstrb);
            ctrl_d[n] = wtmp[2:0];
          end
          4'h4: begin
            wtmp = merge(32'(reload_q[n]), s_axi_wdata, s_axi_wstrb);
            reload_d[n] = wtmp[CNT_W-1:0];
          end
`ifdef TIMER_PWM_EN
          4'hC: begin
            wtmp = merge(32'(cmp_q[n]), s_axi_wdata, s_axi_wstrb);
            cmp_d[n] = wtmp[CNT_W-1:0];
          end
`endif
          default: ;
        endcase
      end
    end
    if (wr_fire && s_axi_awaddr == 12'h000) begin
      wtmp    = merge(32'(presc_q), s_axi_wdata, s_axi_wstrb);
      presc_d = wtmp[PRESC_W-1:0];
    end
    if (wr_fire && s_axi_awaddr == 12'h004) begin
      wtmp = s_axi_wdata & smask(s_axi_wstrb);
      clr  = wtmp[NUM_CH-1:0];
    end
    pend_d = (pend_q & ~clr) | hit;
  end

  // read data mux; unmapped offsets fall through to zero
  always_comb begin
    rd_mux = '0;
    if (s_axi_araddr == 12'h000) rd_mux = 32'(presc_q);
    if (s_axi_araddr == 12'h004) rd_mux = 32'(pend_q);
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel(s_axi_araddr, n)) begin
        case (s_axi_araddr[3:0])
          4'h0:    rd_mux = 32'(ctrl_q[n]);
          4'h4:    rd_mux = 32'(reload_q[n]);
          4'h8:    rd_mux = 32'(count_q[n]);
`ifdef TIMER_PWM_EN
          4'hC:    rd_mux = 32'(cmp_q[n]);
`endif
          default: ;
        endcase
      end
    end
  end

  // timer state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      psc_q   <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n]   <= '0;
        reload_q[n] <= '1;
        count_q[n]  <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      pend_q   <= pend_d;
      irq_q    <= |(pend_q & ien);
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  // AXI-lite response channels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= mapped(s_axi_awaddr, 1'b1) ? OKAY : SLVERR;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        if (mapped(s_axi_araddr, 1'b0)) begin
          rresp_q <= OKAY;
          rdata_q <= rd_mux;
        end else begin
          rresp_q <= SLVERR;
          rdata_q <= '0;
        end
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef TIMER_PWM_EN
  // PWM compare, registered per channel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_q <= '0;
      for (int n = 0; n < NUM_CH; n++) cmp_q[n] <= '1;
    end else begin
      cmp_q <= cmp_d;
      for (int n = 0; n < NUM_CH; n++)
        pwm_q[n] <= ctrl_q[n][0] & (count_q[n] < cmp_q[n]);
    end
  end
`endif

endmodule

// File: tb/tb_axi_timer_mc.sv
// tb_axi_timer_mc: scoreboard bench for axi_timer_mc.
// Directed CSR traffic; B/R responses checked by a monitor.
module tb_axi_timer_mc;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready, irq;
`ifdef TIMER_PWM_EN
  logic [3:0]  pwm;
`endif

  axi_timer_mc dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
`ifdef TIMER_PWM_EN
    .pwm_out(pwm),
`endif
    .irq_out(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int last_fire = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  exp_t mb, mr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic wait_until(int c);
    if (cyc > c) chk("sched", cyc, c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d,
                    logic [3:0] s, logic [1:0] r);
    exp_t e;
    int   n = 0;
    e.a = a; e.d = d; e.r = r;
    bq.push_back(e);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chkb($sformatf("awready@%03h", a), awready, 1'b1);
    if (!awready) void'(bq.pop_back());
    last_fire = cyc + 1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic rd(logic [11:0] a, logic [31:0] d, logic [1:0] r);
    exp_t e;
    int   n = 0;
    e.a = a; e.d = d; e.r = r;
    rq.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chkb($sformatf("arready@%03h", a), arready, 1'b1);
    if (!arready) void'(rq.pop_back());
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // response monitor: pops the scoreboard on every B/R handshake
  always @(negedge clk) begin
    if (resetn && bvalid && bready) begin
      if (bq.size() == 0) begin
        chkb("b_unexpected", bvalid, 1'b0);
      end else begin
        mb = bq.pop_front();
        chk($sformatf("bresp@%03h", mb.a), {30'b0, bresp}, {30'b0, mb.r});
      end
    end
    if (resetn && rvalid && rready) begin
      if (rq.size() == 0) begin
        chkb("r_unexpected", rvalid, 1'b0);
      end else begin
        mr = rq.pop_front();
        chk($sformatf("rdata@%03h", mr.a), rdata, mr.d);
        chk($sformatf("rresp@%03h", mr.a), {30'b0, rresp}, {30'b0, mr.r});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int g;
    int hi;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1;
    repeat (2) @(negedge clk);
    chkb("rst_awready", awready, 1'b0);
    chkb("rst_wready", wready, 1'b0);
    chkb("rst_arready", arready, 1'b0);
    chkb("rst_bvalid", bvalid, 1'b0);
    chkb("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bresp", {30'b0, bresp}, 32'h0);
    chk("rst_rresp", {30'b0, rresp}, 32'h0);
    chkb("rst_irq", irq, 1'b0);
    resetn = 1'b1;

    rd(12'h000, 32'h0, OK);
    rd(12'h004, 32'h0, OK);
    rd(12'h100, 32'h0, OK);
    rd(12'h104, 32'hFFFF_FFFF, OK);
    rd(12'h108, 32'h0, OK);
`ifdef TIMER_PWM_EN
    rd(12'h10C, 32'hFFFF_FFFF, OK);
`else
    rd(12'h10C, 32'h0, SLV);
`endif

    // reset while a write response is outstanding
    bready = 1'b0;
    @(negedge clk);
    awaddr = 12'h000; wdata = 32'h5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chkb("mid_bvalid", bvalid, 1'b1);
    #2 resetn = 1'b0;
    #1 chkb("mid_bvalid_rst", bvalid, 1'b0);
    @(negedge clk);
    resetn = 1'b1; bready = 1'b1;
    rd(12'h000, 32'h0, OK);

    // periodic ch0: prescale 4, reload 4 -> hit every 20 cycles
    wr(12'h000, 32'd3, 4'hF, OK);
    wr(12'h104, 32'd4, 4'hF, OK);
    wr(12'h100, 32'h5, 4'hF, OK);
    e = last_fire;
    for (int k = 0; k < 5; k++) begin
      wait_until(e + 4 * k + 1);
      rd(12'h108, 32'(k), OK);
    end
    wait_until(e + 20);
    chkb("irq_before_hit", irq, 1'b0);
    wait_until(e + 21);
    chkb("irq_first_hit", irq, 1'b1);
    wait_until(e + 24);
    wr(12'h004, 32'h1, 4'hF, OK);
    wait_until(e + 30);
    chkb("irq_after_w1c", irq, 1'b0);
    wait_until(e + 38);
    chkb("irq_before_2nd", irq, 1'b0);
    wr(12'h004, 32'h1, 4'hF, OK);
    wait_until(e + 41);
    chkb("irq_set_wins", irq, 1'b1);
    rd(12'h004, 32'h1, OK);
    wait_until(e + 44);
    wr(12'h004, 32'h1, 4'hF, OK);
    wait_until(e + 48);
    chkb("irq_cleared", irq, 1'b0);
    rd(12'h004, 32'h0, OK);
    wait_until(e + 52);
    wr(12'h100, 32'h0, 4'hF, OK);
    rd(12'h108, 32'h0, OK);
    rd(12'h100, 32'h0, OK);

    // one-shot ch1
    wr(12'h114, 32'd2, 4'hF, OK);
    wr(12'h110, 32'h7, 4'hF, OK);
    repeat (30) @(negedge clk);
    rd(12'h110, 32'h6, OK);
    rd(12'h004, 32'h2, OK);
    chkb("irq_oneshot", irq, 1'b1);
    rd(12'h118, 32'h0, OK);
    wr(12'h004, 32'h2, 4'hF, OK);
    repeat (40) @(negedge clk);
    rd(12'h004, 32'h0, OK);
    chkb("irq_no_2nd_shot", irq, 1'b0);

    // error responses and byte strobes
    rd(12'h1F0, 32'h0, SLV);
    rd(12'h008, 32'h0, SLV);
    wr(12'h108, 32'hFFFF_FFFF, 4'hF, SLV);
    rd(12'h108, 32'h0, OK);
    wr(12'h124, 32'h1234_5678, 4'h1, OK);
    rd(12'h124, 32'hFFFF_FF78, OK);
    wr(12'h124, 32'h00AB_CD00, 4'h6, OK);
    rd(12'h124, 32'hFFAB_CD78, OK);

    // RELOAD=0 hits every tick; no irq without irq_en
    wr(12'h000, 32'd0, 4'hF, OK);
    wr(12'h134, 32'd0, 4'hF, OK);
    wr(12'h130, 32'h1, 4'hF, OK);
    repeat (4) @(negedge clk);
    rd(12'h004, 32'h8, OK);
    chkb("irq_gated", irq, 1'b0);
    rd(12'h138, 32'h0, OK);
    wr(12'h130, 32'h0, 4'hF, OK);
    wr(12'h004, 32'h8, 4'hF, OK);
    rd(12'h004, 32'h0, OK);

`ifdef TIMER_PWM_EN
    wr(12'h104, 32'd9, 4'hF, OK);
    wr(12'h10C, 32'd3, 4'hF, OK);
    wr(12'h100, 32'h1, 4'hF, OK);
    repeat (5) @(negedge clk);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm[0]) hi++;
    end
    chk("pwm_duty", hi, 6);
    wr(12'h10C, 32'd0, 4'hF, OK);
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm[0]) hi++;
    end
    chk("pwm_cmp0", hi, 0);
    wr(12'h100, 32'h0, 4'hF, OK);
`endif

    g = 0;
    while ((bq.size() != 0 || rq.size() != 0) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("sb_drain", 32'(bq.size() + rq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
